// File: rtl/fir_out_collector.sv
// fir_out_collector: sink for the FIR output stream.
// Buffers accepted samples in a DEPTH-entry FIFO for a downstream reader and
// keeps a saturating sample count and a rotate-XOR checksum of the stream.
// DONE is raised once N_SAMPLES samples have been accepted. After that the
// input side is frozen, while reads can still drain the FIFO.
//
// Ports
//   CLK       clock, rising edge
//   RST       asynchronous active-high reset
//   VIN/DIN   input sample valid / two's-complement sample (from filter)
//   RD_EN     pop request from the reader
//   RD_DATA   popped sample, valid the cycle after the pop
//   RD_VALID  RD_DATA holds a sample popped on the previous cycle
//   EMPTY     FIFO holds no samples
//   FULL      FIFO holds DEPTH samples
//   OVERFLOW  sticky: at least one accepted sample could not be buffered
//   COUNT     samples accepted since reset (saturating)
//   CHECKSUM  rolling checksum of accepted samples
//   DONE      sticky: COUNT reached N_SAMPLES
module fir_out_collector #(
  parameter int unsigned DW        = 11,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned N_SAMPLES = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VIN,
  input  logic [DW-1:0] DIN,
  input  logic          RD_EN,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_VALID,
  output logic          EMPTY,
  output logic          FULL,
  output logic          OVERFLOW,
  output logic [15:0]   COUNT,
  output logic [31:0]   CHECKSUM,
  output logic          DONE
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [DW-1:0]   r_mem [DEPTH];

  logic [DW-1:0]   r_rd_data;
  logic            r_rd_valid;
  logic            r_empty;
  logic            r_full;
  logic            r_overflow;
  logic [15:0]     r_count;
  logic [31:0]     r_checksum;
  logic            r_done;

  logic            w_accept;
  logic            w_last;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [15:0]     w_count_nxt;
  logic [31:0]     w_checksum_nxt;
  logic [31:0]     w_din_sext;

  // Next-state logic and per-cycle datapath decisions
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_last         = 1'b0;
    w_pop          = 1'b0;
    w_push         = 1'b0;
    w_drop         = 1'b0;
    w_din_sext     = 32'($signed(DIN));
    w_count_nxt    = r_count;
    w_checksum_nxt = r_checksum;

    // Input is only taken while not yet done
    w_accept = VIN && (r_state != S_DONE);
    // Compare in 32 bits so N_SAMPLES above 16 bits never matches
    w_last   = w_accept && ((32'(r_count) + 32'd1) == 32'(N_SAMPLES));

    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_last ? S_DONE : S_RUN;
      S_RUN:  if (w_last)   w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase

    // A pop on a full FIFO frees the slot the same-cycle write reuses;
    // a pop on an empty FIFO is ignored (no fall-through)
    w_pop  = RD_EN && !r_empty;
    w_push = w_accept && (!r_full || w_pop);
    w_drop = w_accept && r_full && !w_pop;

    if (w_accept) begin
      w_count_nxt    = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
      w_checksum_nxt = {r_checksum[30:0], r_checksum[31]} ^ w_din_sext;
    end
  end

  assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_push);
  assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_pop);

  // State, pointers, flags and counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_count    <= '0;
      r_checksum <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_rd_valid <= w_pop;
      if (w_pop) r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      // Flags track the pointer values being registered this edge
      r_empty    <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_full     <= ((w_wr_ptr_nxt - w_rd_ptr_nxt) == PW'(DEPTH));
      if (w_drop) r_overflow <= 1'b1;
      r_count    <= w_count_nxt;
      r_checksum <= w_checksum_nxt;
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  // FIFO storage; contents are discarded on reset via the pointers
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= DIN;
  end

  assign RD_DATA  = r_rd_data;
  assign RD_VALID = r_rd_valid;
  assign EMPTY    = r_empty;
  assign FULL     = r_full;
  assign OVERFLOW = r_overflow;
  assign COUNT    = r_count;
  assign CHECKSUM = r_checksum;
  assign DONE     = r_done;

endmodule

// File: tb/tb_fir_out_collector.sv
// Bench for fir_out_collector: two instances (DEPTH=16/N=4 and DEPTH=4/N=20)
// share the stimulus and are compared every cycle against a queue-based
// model of the stream, plus directed checks on the key scenarios.
module tb_fir_out_collector;

  localparam int unsigned DW = 11;
  localparam int D0 = 16;
  localparam int N0 = 4;
  localparam int D1 = 4;
  localparam int N1 = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          vin;
  logic          rd_en;
  logic [DW-1:0] din;

  logic [DW-1:0] o_rd  [2];
  logic          o_rv  [2];
  logic          o_em  [2];
  logic          o_fu  [2];
  logic          o_ov  [2];
  logic [15:0]   o_cnt [2];
  logic [31:0]   o_cs  [2];
  logic          o_dn  [2];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            m_cnt [2];
  logic [31:0]   m_cs  [2];
  logic          m_ovf [2];
  logic          m_done[2];
  logic          m_rv  [2];
  logic [DW-1:0] m_rd  [2];

  always #5 clk = ~clk;

  fir_out_collector #(.DW(DW), .DEPTH(D0), .N_SAMPLES(N0)) u_dut0 (
    .CLK(clk), .RST(rst), .VIN(vin), .DIN(din), .RD_EN(rd_en),
    .RD_DATA(o_rd[0]), .RD_VALID(o_rv[0]), .EMPTY(o_em[0]), .FULL(o_fu[0]),
    .OVERFLOW(o_ov[0]), .COUNT(o_cnt[0]), .CHECKSUM(o_cs[0]), .DONE(o_dn[0])
  );

  fir_out_collector #(.DW(DW), .DEPTH(D1), .N_SAMPLES(N1)) u_dut1 (
    .CLK(clk), .RST(rst), .VIN(vin), .DIN(din), .RD_EN(rd_en),
    .RD_DATA(o_rd[1]), .RD_VALID(o_rv[1]), .EMPTY(o_em[1]), .FULL(o_fu[1]),
    .OVERFLOW(o_ov[1]), .COUNT(o_cnt[1]), .CHECKSUM(o_cs[1]), .DONE(o_dn[1])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_cs[k]   = 32'd0;
      m_ovf[k]  = 1'b0;
      m_done[k] = 1'b0;
      m_rv[k]   = 1'b0;
      m_rd[k]   = '0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock of stream behaviour for instance k: pop first, then buffer
  task automatic model_one(input int k, input int dep, input int ns);
    logic [DW-1:0] q[$];
    logic          acc;
    if (k == 0) q = q0; else q = q1;
    acc = vin && !m_done[k];
    if (rd_en && q.size() > 0) begin
      m_rd[k] = q.pop_front();
      m_rv[k] = 1'b1;
    end else begin
      m_rv[k] = 1'b0;
    end
    if (acc) begin
      if (m_cnt[k] < 65535) m_cnt[k]++;
      m_cs[k] = {m_cs[k][30:0], m_cs[k][31]} ^ 32'($signed(din));
      if (q.size() < dep) q.push_back(din);
      else                m_ovf[k] = 1'b1;
      if (m_cnt[k] == ns) m_done[k] = 1'b1;
    end
    if (k == 0) q0 = q; else q1 = q;
  endtask

  task automatic compare_all();
    int sz;
    int dep;
    for (int k = 0; k < 2; k++) begin
      sz  = (k == 0) ? q0.size() : q1.size();
      dep = (k == 0) ? D0 : D1;
      check_val($sformatf("u%0d.rd_valid", k), 32'(o_rv[k]),  32'(m_rv[k]));
      check_val($sformatf("u%0d.rd_data", k),  32'(o_rd[k]),  32'(m_rd[k]));
      check_val($sformatf("u%0d.empty", k),    32'(o_em[k]),  32'(sz == 0));
      check_val($sformatf("u%0d.full", k),     32'(o_fu[k]),  32'(sz == dep));
      check_val($sformatf("u%0d.overflow", k), 32'(o_ov[k]),  32'(m_ovf[k]));
      check_val($sformatf("u%0d.count", k),    32'(o_cnt[k]), 32'(m_cnt[k]));
      check_val($sformatf("u%0d.checksum", k), o_cs[k],       m_cs[k]);
      check_val($sformatf("u%0d.done", k),     32'(o_dn[k]),  32'(m_done[k]));
    end
  endtask

  // Drive inputs, advance one edge, update model, compare everything
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    vin   = v;
    din   = d;
    rd_en = r;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_one(0, D0, N0);
      model_one(1, D1, N1);
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_b [4];
    logic [31:0]   cs_hold;
    int            rd_prob;
    rst   = 1'b1;
    vin   = 1'b0;
    din   = '0;
    rd_en = 1'b0;
    model_reset();

    // Reset held 3 cycles, then idle
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
    check_val("idle.empty0", 32'(o_em[0]), 32'd1);
    check_val("idle.done0",  32'(o_dn[0]), 32'd0);

    // Stream of four samples into the N=4 instance, then read back
    exp_b[0] = 11'h001; exp_b[1] = 11'h002; exp_b[2] = 11'h7FF; exp_b[3] = 11'h005;
    for (int i = 0; i < 4; i++) step(1'b1, exp_b[i], 1'b0);
    check_val("stream.count0", 32'(o_cnt[0]), 32'd4);
    check_val("stream.done0",  32'(o_dn[0]),  32'd1);
    // 1 -> rot(1)^2=0 -> 0^~0=~0 -> rot(~0)^5
    check_val("stream.cksum0", o_cs[0], 32'hFFFF_FFFA);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      check_val($sformatf("stream.rd%0d", i), 32'(o_rd[0]), 32'(exp_b[i]));
      check_val($sformatf("stream.rv%0d", i), 32'(o_rv[0]), 32'd1);
    end
    check_val("stream.empty0", 32'(o_em[0]), 32'd1);
    step(1'b0, '0, 1'b1);
    check_val("emptyrd.rv0",   32'(o_rv[0]), 32'd0);
    check_val("emptyrd.hold0", 32'(o_rd[0]), 32'h005);
    cs_hold = o_cs[0];
    for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
    check_val("postdone.count0", 32'(o_cnt[0]), 32'd4);
    check_val("postdone.cksum0", o_cs[0], cs_hold);
    check_val("postdone.empty0", 32'(o_em[0]), 32'd1);

    // Overflow on the DEPTH=4 instance
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 4) begin
        check_val("ovf.full4", 32'(o_fu[1]), 32'd1);
        check_val("ovf.ovf4",  32'(o_ov[1]), 32'd0);
      end
      if (i == 5) check_val("ovf.ovf5", 32'(o_ov[1]), 32'd1);
    end
    check_val("ovf.count", 32'(o_cnt[1]), 32'd6);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, '0, 1'b1);
      if (i <= 4) check_val($sformatf("ovf.rd%0d", i), 32'(o_rd[1]), 32'(i));
      else        check_val("ovf.rv_end", 32'(o_rv[1]), 32'd0);
    end

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 11; i <= 14; i++) step(1'b1, DW'(i), 1'b0);
    check_val("fpp.full_before", 32'(o_fu[1]), 32'd1);
    step(1'b1, DW'(15), 1'b1);
    check_val("fpp.full_after", 32'(o_fu[1]), 32'd1);
    check_val("fpp.ovf",        32'(o_ov[1]), 32'd0);
    check_val("fpp.rd11",       32'(o_rd[1]), 32'd11);
    for (int i = 12; i <= 15; i++) begin
      step(1'b0, '0, 1'b1);
      check_val($sformatf("fpp.rd%0d", i), 32'(o_rd[1]), 32'(i));
    end

    // Asynchronous reset in the middle of a cycle
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(i + 9), 1'b0);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("arst.count%0d", k), 32'(o_cnt[k]), 32'd0);
      check_val($sformatf("arst.cksum%0d", k), o_cs[k],       32'd0);
      check_val($sformatf("arst.empty%0d", k), 32'(o_em[k]),  32'd1);
      check_val($sformatf("arst.ovf%0d", k),   32'(o_ov[k]),  32'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
    step(1'b1, DW'(3), 1'b0);
    check_val("arst.count_after", 32'(o_cnt[1]), 32'd1);

    // Randomized blocks, each from a fresh reset
    for (int b = 0; b < 10; b++) begin
      do_reset();
      rd_prob = int'($urandom_range(0, 3));
      for (int i = 0; i < 60; i++)
        step(($urandom_range(0, 3) != 0), DW'($urandom),
             (int'($urandom_range(0, 3)) < rd_prob));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
